// File: rtl/seq_signed_div_pkg.sv
// Shared widths, state encoding and operand/result types for the sequential signed divider.
// Dividend width matches the booth multiplier product; quotient shares it.
package seq_signed_div_pkg;
  localparam int DVD_W = 19;
  localparam int DVR_W = 5;
  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

  typedef logic signed [DVD_W-1:0] dvd_t;
  typedef logic        [DVD_W-1:0] dvd_mag_t;
  typedef logic signed [DVR_W-1:0] dvr_t;
  typedef logic        [DVR_W-1:0] dvr_mag_t;
  typedef logic        [CNT_W-1:0] cnt_t;

  // The most negative value maps to its magnitude as an unsigned number of the same width.
  function automatic dvd_mag_t dvd_abs(input dvd_t v);
    return v[DVD_W-1] ? dvd_mag_t'(-v) : dvd_mag_t'(v);
  endfunction

  function automatic dvr_mag_t dvr_abs(input dvr_t v);
    return v[DVR_W-1] ? dvr_mag_t'(-v) : dvr_mag_t'(v);
  endfunction
endpackage

// File: rtl/seq_signed_div_if.sv
// en/valid handshake bundle shared by the divider and the execute-stage driver.
interface seq_signed_div_if;
  import seq_signed_div_pkg::*;

  logic div_en;
  dvd_t dividend;
  dvr_t divisor;
  logic div_busy;
  logic div_out_valid;
  dvd_t quotient;
  dvr_t remainder;
  logic div_by_zero;
  logic div_ovf;

  modport master (
    output div_en, dividend, divisor,
    input  div_busy, div_out_valid, quotient, remainder, div_by_zero, div_ovf
  );

  modport slave (
    input  div_en, dividend, divisor,
    output div_busy, div_out_valid, quotient, remainder, div_by_zero, div_ovf
  );
endinterface

// File: rtl/seq_signed_div_step.sv
// One unsigned restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module seq_signed_div_step
  import seq_signed_div_pkg::*;
(
  input  dvr_mag_t i_prem,
  input  logic     i_bit,
  input  dvr_mag_t i_dvr,
  output dvr_mag_t o_prem,
  output logic     o_qbit
);
  logic [DVR_W:0] w_part;
  dvr_mag_t       w_diff;

  assign w_part = {i_prem, i_bit};
  assign o_qbit = (w_part >= {1'b0, i_dvr});
  // The difference is below the divisor, so the dropped carry bit is always zero.
  assign w_diff = w_part[DVR_W-1:0] - i_dvr;
  assign o_prem = o_qbit ? w_diff : w_part[DVR_W-1:0];
endmodule

// File: rtl/seq_signed_div.sv
// Iterative signed divider, one quotient bit per clock, truncating toward zero.
// state | meaning
// IDLE  | waiting for div_en; divide-by-zero answered here directly
// CALC  | DVD_W restoring iterations on operand magnitudes
// FIX   | apply signs, register results, pulse div_out_valid
module seq_signed_div
  import seq_signed_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  seq_signed_div_if.slave   bus
);
  localparam dvd_t DVD_MIN = {1'b1, {(DVD_W-1){1'b0}}};

  div_state_t r_state;
  dvd_mag_t   r_q;
  dvr_mag_t   r_prem;
  dvr_mag_t   r_dvr;
  cnt_t       r_cnt;
  logic       r_neg_q;
  logic       r_neg_r;
  logic       r_ovf_pend;
  dvd_t       r_quot;
  dvr_t       r_rem;
  logic       r_valid;
  logic       r_dbz;
  logic       r_ovf;

  dvr_mag_t   w_prem;
  logic       w_qbit;

  seq_signed_div_step u_step (
    .i_prem (r_prem),
    .i_bit  (r_q[DVD_W-1]),
    .i_dvr  (r_dvr),
    .o_prem (w_prem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_q        <= '0;
      r_prem     <= '0;
      r_dvr      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_valid    <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.div_en) begin
            if (bus.divisor == '0) begin
              r_quot  <= '1;
              r_rem   <= '0;
              r_dbz   <= 1'b1;
              r_ovf   <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_q        <= dvd_abs(bus.dividend);
              r_dvr      <= dvr_abs(bus.divisor);
              r_prem     <= '0;
              r_cnt      <= cnt_t'(DVD_W);
              r_neg_q    <= bus.dividend[DVD_W-1] ^ bus.divisor[DVR_W-1];
              r_neg_r    <= bus.dividend[DVD_W-1];
              r_ovf_pend <= (bus.dividend == DVD_MIN) && (bus.divisor == '1);
              r_state    <= CALC;
            end
          end
        end
        CALC: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          r_q    <= {r_q[DVD_W-2:0], w_qbit};
          r_prem <= w_prem;
          r_cnt  <= r_cnt - cnt_t'(1);
          if (r_cnt == cnt_t'(1)) r_state <= FIX;
        end
        FIX: begin
          r_quot  <= r_neg_q ? dvd_t'(-r_q) : dvd_t'(r_q);
          r_rem   <= r_neg_r ? dvr_t'(-r_prem) : dvr_t'(r_prem);
          r_dbz   <= 1'b0;
          r_ovf   <= r_ovf_pend;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.div_busy      = (r_state != IDLE);
  assign bus.div_out_valid = r_valid;
  assign bus.quotient      = r_quot;
  assign bus.remainder     = r_rem;
  assign bus.div_by_zero   = r_dbz;
  assign bus.div_ovf       = r_ovf;
endmodule

// File: tb/tb_seq_signed_div.sv
// Scoreboard bench for seq_signed_div: driver pushes reference results, monitor checks on valid.
module tb_seq_signed_div;
  import seq_signed_div_pkg::*;

  typedef struct {
    int   a;
    int   b;
    dvd_t q;
    dvr_t r;
    bit   dbz;
    bit   ovf;
    int   edge_n;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   busy_start;
  int   busy_end;
  exp_t sb[$];

  seq_signed_div_if bus ();

  seq_signed_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: plain integer division truncates toward zero, % follows the dividend sign.
  function automatic exp_t ref_model(input int a, input int b);
    exp_t e;
    int   q;
    int   r;
    e.a = a;
    e.b = b;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      q = -1;
      r = 0;
      e.dbz = 1'b1;
    end else if (a == -(1 << (DVD_W-1)) && b == -1) begin
      q = a;
      r = 0;
      e.ovf = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
    e.q = dvd_t'(q);
    e.r = dvr_t'(r);
    e.edge_n = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (!rst) begin
      exp_busy = (cyc >= busy_start) && (cyc < busy_end);
      n_vec++;
      if (bus.div_busy !== exp_busy) begin
        n_bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.div_busy, exp_busy);
      end
      if (bus.div_out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid cyc=%0d q=%0d r=%0d", cyc, bus.quotient, bus.remainder);
        end else begin
          e = sb.pop_front();
          if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz ||
              bus.div_ovf !== e.ovf || cyc != e.edge_n) begin
            n_bad++;
            $display("FAIL result %0d/%0d got q=%0d r=%0d dbz=%b ovf=%b edge=%0d exp q=%0d r=%0d dbz=%b ovf=%b edge=%0d",
                     e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, bus.div_ovf, cyc,
                     e.q, e.r, e.dbz, e.ovf, e.edge_n);
          end
        end
      end
    end
  end

  task automatic do_op(input int a, input int b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (bus.div_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.div_busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout got busy=%b exp=0", bus.div_busy);
    end
    bus.div_en   = 1'b1;
    bus.dividend = dvd_t'(a);
    bus.divisor  = dvr_t'(b);
    @(posedge clk);
    #1;
    bus.div_en = 1'b0;
    e = ref_model(a, b);
    e.edge_n = e.dbz ? cyc : cyc + DVD_W + 1;
    if (!e.dbz) begin
      busy_start = cyc;
      busy_end   = cyc + DVD_W + 1;
    end
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (bus.div_busy !== 1'b0 || bus.div_out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0 || bus.div_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL %s got busy=%b valid=%b q=%0d r=%0d dbz=%b ovf=%b exp all 0", tag,
               bus.div_busy, bus.div_out_valid, bus.quotient, bus.remainder,
               bus.div_by_zero, bus.div_ovf);
    end
  endtask

  initial begin
    dvd_t ra;
    dvr_t rb;
    int   n;
    cyc = 0;
    n_vec = 0;
    n_bad = 0;
    busy_start = 0;
    busy_end = 0;
    rst = 1'b1;
    bus.div_en = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    check_zero("reset_state");
    @(posedge clk);
    #3 rst = 1'b0;

    do_op(-147456, -16);
    do_op(100, 7);
    do_op(-100, 7);
    do_op(100, -7);
    do_op(-100, -7);
    do_op(5, 0);
    do_op(-262144, -1);
    do_op(-262144, 1);
    do_op(262143, -16);

    // Requests while busy must be dropped; the follow-up lands in the valid cycle.
    do_op(1000, 3);
    @(negedge clk);
    bus.div_en = 1'b1;
    bus.dividend = dvd_t'(50);
    bus.divisor = dvr_t'(5);
    repeat (5) @(negedge clk);
    bus.div_en = 1'b0;
    do_op(50, 5);

    do_op(1000, 3);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    busy_start = 0;
    busy_end = 0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #3 rst = 1'b0;
    do_op(-7, 2);

    for (int i = 0; i < 40; i++) begin
      ra = dvd_t'($urandom);
      rb = dvr_t'($urandom);
      if (i % 10 == 3) ra = {1'b1, {(DVD_W-1){1'b0}}};
      do_op(int'(ra), int'(rb));
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout got pending=%0d exp 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
